// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with priority redirects, fetch handshake and return-address stack
module pc_gen #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_ADDR = '0,
  parameter int unsigned          INST_BYTES = 4,
  parameter int unsigned          RAS_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             jtag_reset_flag_i,
  input  logic                             trap_flag_i,
  input  logic [ADDR_W-1:0]                trap_addr_i,
  input  logic                             predict_error_i,
  input  logic                             jump_flag_i,
  input  logic [ADDR_W-1:0]                jump_addr_i,
  input  logic                             hold_flag_i,
  input  logic                             bp_valid_i,
  input  logic                             bp_taken_i,
  input  logic [ADDR_W-1:0]                bp_addr_i,
  input  logic                             bp_is_call_i,
  input  logic                             bp_is_ret_i,
  input  logic                             fetch_ready_i,
  output logic [ADDR_W-1:0]                pc_o,
  output logic                             pc_valid_o,
  output logic                             redirect_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count_o
);

  localparam int unsigned       PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned       CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_BYTES);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic              r_redirect;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ras_ptr;
  logic [CNT_W-1:0]  r_ras_cnt;

  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_ras_top;
  logic [PTR_W-1:0]  w_ras_ptr_next;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [CNT_W-1:0]  w_ras_cnt_next;
  logic              w_advance;
  logic              w_taken;
  logic              w_redirect;
  logic              w_flush;
  logic              w_pop;
  logic              w_push;

  assign w_seq     = r_pc + STEP;
  assign w_ras_top = r_ras[r_ras_ptr - PTR_W'(1)];
  assign w_advance = r_valid && fetch_ready_i && !hold_flag_i;
  assign w_taken   = bp_valid_i && bp_taken_i;
  assign w_flush   = jtag_reset_flag_i || trap_flag_i || predict_error_i;

  always_comb begin
    w_pc_next  = r_pc;
    w_redirect = 1'b0;
    w_pop      = 1'b0;
    w_push     = 1'b0;
    if (jtag_reset_flag_i) begin
      w_pc_next = RESET_ADDR;
    end else if (trap_flag_i) begin
      w_pc_next  = trap_addr_i;
      w_redirect = 1'b1;
    end else if (predict_error_i || jump_flag_i) begin
      w_pc_next  = jump_addr_i;
      w_redirect = 1'b1;
    end else if (w_advance) begin
      w_pc_next = w_seq;
      if (w_taken) begin
        w_push = bp_is_call_i;
        if (bp_is_ret_i && (r_ras_cnt != '0)) begin
          w_pop     = 1'b1;
          w_pc_next = w_ras_top;
        end else if (bp_addr_i != '0) begin
          w_pc_next = bp_addr_i;
        end
      end
    end
  end

  // Pointer marks the next free slot; a full push silently overwrites the oldest entry.
  always_comb begin
    w_ras_ptr_next = r_ras_ptr;
    w_ras_cnt_next = r_ras_cnt;
    w_wr_idx       = r_ras_ptr;
    if (w_flush) begin
      w_ras_cnt_next = '0;
    end else if (w_pop && w_push) begin
      w_wr_idx = r_ras_ptr - PTR_W'(1);
    end else if (w_pop) begin
      w_ras_ptr_next = r_ras_ptr - PTR_W'(1);
      w_ras_cnt_next = r_ras_cnt - CNT_W'(1);
    end else if (w_push) begin
      w_ras_ptr_next = r_ras_ptr + PTR_W'(1);
      w_ras_cnt_next = (r_ras_cnt == FULL) ? FULL : r_ras_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_ras[w_wr_idx] <= w_seq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_ADDR;
      r_valid    <= 1'b0;
      r_redirect <= 1'b0;
      r_ras_ptr  <= '0;
      r_ras_cnt  <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_valid    <= !jtag_reset_flag_i;
      r_redirect <= w_redirect;
      r_ras_ptr  <= w_ras_ptr_next;
      r_ras_cnt  <= w_ras_cnt_next;
    end
  end

  assign pc_o        = r_pc;
  assign pc_valid_o  = r_valid;
  assign redirect_o  = r_redirect;
  assign ras_count_o = r_ras_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - vector table plus randomized queue-model check of pc_gen
module tb_pc_gen;

  localparam int RAS_DEPTH = 4;
  localparam int C_JTAG = 1, C_TRAP = 2, C_PE = 4, C_JMP = 8, C_HOLD = 16;
  localparam int C_NRDY = 32, C_BP = 64, C_CALL = 128, C_RET = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        jtag_reset_flag_i, trap_flag_i, predict_error_i, jump_flag_i, hold_flag_i;
  logic [31:0] trap_addr_i, jump_addr_i, bp_addr_i;
  logic        bp_valid_i, bp_taken_i, bp_is_call_i, bp_is_ret_i, fetch_ready_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, redirect_o;
  logic [2:0]  ras_count_o;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int          ctl;
    logic [31:0] taddr, jaddr, baddr;
    logic [31:0] epc;
    logic        evalid, eredir;
    int          ecnt;
  } vec_t;

  vec_t tbl[$];

  logic [31:0] m_pc;
  logic        m_valid, m_redir;
  logic [31:0] m_ras[$];

  pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .INST_BYTES(4), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .jtag_reset_flag_i(jtag_reset_flag_i), .trap_flag_i(trap_flag_i), .trap_addr_i(trap_addr_i),
    .predict_error_i(predict_error_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .bp_valid_i(bp_valid_i), .bp_taken_i(bp_taken_i),
    .bp_addr_i(bp_addr_i), .bp_is_call_i(bp_is_call_i), .bp_is_ret_i(bp_is_ret_i),
    .fetch_ready_i(fetch_ready_i), .pc_o(pc_o), .pc_valid_o(pc_valid_o),
    .redirect_o(redirect_o), .ras_count_o(ras_count_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(int ctl, logic [31:0] ta, logic [31:0] ja, logic [31:0] ba,
                             logic [31:0] epc, logic ev, logic er, int ec);
    vec_t r;
    r.ctl = ctl; r.taddr = ta; r.jaddr = ja; r.baddr = ba;
    r.epc = epc; r.evalid = ev; r.eredir = er; r.ecnt = ec;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(int ctl, logic [31:0] ta, logic [31:0] ja, logic [31:0] ba);
    jtag_reset_flag_i = (ctl & C_JTAG) != 0;
    trap_flag_i       = (ctl & C_TRAP) != 0;
    predict_error_i   = (ctl & C_PE) != 0;
    jump_flag_i       = (ctl & C_JMP) != 0;
    hold_flag_i       = (ctl & C_HOLD) != 0;
    fetch_ready_i     = (ctl & C_NRDY) == 0;
    bp_valid_i        = (ctl & C_BP) != 0;
    bp_taken_i        = (ctl & C_BP) != 0;
    bp_is_call_i      = (ctl & C_CALL) != 0;
    bp_is_ret_i       = (ctl & C_RET) != 0;
    trap_addr_i = ta; jump_addr_i = ja; bp_addr_i = ba;
  endtask

  // Reference: priority list over the current inputs, RAS as a bounded queue (back = top).
  task automatic model_edge();
    logic [31:0] seq, nxt;
    seq = m_pc + 32'd4;
    nxt = m_pc;
    m_redir = 1'b0;
    if (jtag_reset_flag_i) nxt = 32'h0;
    else if (trap_flag_i) begin nxt = trap_addr_i; m_redir = 1'b1; end
    else if (predict_error_i || jump_flag_i) begin nxt = jump_addr_i; m_redir = 1'b1; end
    else if (m_valid && fetch_ready_i && !hold_flag_i) begin
      nxt = seq;
      if (bp_valid_i && bp_taken_i) begin
        if (bp_is_ret_i && m_ras.size() > 0) nxt = m_ras.pop_back();
        else if (bp_addr_i != 32'h0) nxt = bp_addr_i;
        if (bp_is_call_i) begin
          m_ras.push_back(seq);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
      end
    end
    if (jtag_reset_flag_i || trap_flag_i || predict_error_i) m_ras.delete();
    m_pc = nxt;
    m_valid = !jtag_reset_flag_i;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".valid"}, {31'b0, pc_valid_o}, {31'b0, m_valid});
    chk({tag, ".redirect"}, {31'b0, redirect_o}, {31'b0, m_redir});
    chk({tag, ".ras_count"}, {29'b0, ras_count_o}, 32'(m_ras.size()));
  endtask

  initial begin
    tbl.push_back(v(0,                    0, 0,        0,        32'h0,        1, 0, 0));
    tbl.push_back(v(0,                    0, 0,        0,        32'h4,        1, 0, 0));
    tbl.push_back(v(0,                    0, 0,        0,        32'h8,        1, 0, 0));
    tbl.push_back(v(0,                    0, 0,        0,        32'hC,        1, 0, 0));
    tbl.push_back(v(C_TRAP|C_PE|C_JMP|C_HOLD, 32'h100, 32'h200, 0, 32'h100,   1, 1, 0));
    tbl.push_back(v(C_PE,                 0, 32'h200,  0,        32'h200,      1, 1, 0));
    tbl.push_back(v(0,                    0, 0,        0,        32'h204,      1, 0, 0));
    tbl.push_back(v(C_JMP,                0, 32'h40,   0,        32'h40,       1, 1, 0));
    tbl.push_back(v(C_NRDY,               0, 0,        0,        32'h40,       1, 0, 0));
    tbl.push_back(v(C_NRDY,               0, 0,        0,        32'h40,       1, 0, 0));
    tbl.push_back(v(C_NRDY,               0, 0,        0,        32'h40,       1, 0, 0));
    tbl.push_back(v(C_NRDY|C_JMP,         0, 32'h80,   0,        32'h80,       1, 1, 0));
    tbl.push_back(v(C_JMP,                0, 32'h10,   0,        32'h10,       1, 1, 0));
    tbl.push_back(v(C_BP|C_CALL,          0, 0,        32'h300,  32'h300,      1, 0, 1));
    tbl.push_back(v(0,                    0, 0,        0,        32'h304,      1, 0, 1));
    tbl.push_back(v(C_BP|C_RET,           0, 0,        0,        32'h14,       1, 0, 0));
    tbl.push_back(v(C_BP|C_RET,           0, 0,        0,        32'h18,       1, 0, 0));
    tbl.push_back(v(C_JMP,                0, 32'h0,    0,        32'h0,        1, 1, 0));
    tbl.push_back(v(C_BP|C_CALL,          0, 0,        32'h100,  32'h100,      1, 0, 1));
    tbl.push_back(v(C_BP|C_CALL,          0, 0,        32'h200,  32'h200,      1, 0, 2));
    tbl.push_back(v(C_BP|C_CALL,          0, 0,        32'h300,  32'h300,      1, 0, 3));
    tbl.push_back(v(C_BP|C_CALL,          0, 0,        32'h400,  32'h400,      1, 0, 4));
    tbl.push_back(v(C_BP|C_CALL,          0, 0,        32'h500,  32'h500,      1, 0, 4));
    tbl.push_back(v(C_BP|C_RET,           0, 0,        32'h9990, 32'h404,      1, 0, 3));
    tbl.push_back(v(C_BP|C_RET,           0, 0,        32'h9990, 32'h304,      1, 0, 2));
    tbl.push_back(v(C_BP|C_RET,           0, 0,        32'h9990, 32'h204,      1, 0, 1));
    tbl.push_back(v(C_BP|C_RET,           0, 0,        0,        32'h104,      1, 0, 0));
    tbl.push_back(v(C_JMP,                0, 32'hFFFF_FFFC, 0,   32'hFFFF_FFFC, 1, 1, 0));
    tbl.push_back(v(0,                    0, 0,        0,        32'h0,        1, 0, 0));
    tbl.push_back(v(C_BP|C_CALL,          0, 0,        32'h700,  32'h700,      1, 0, 1));
    tbl.push_back(v(C_BP|C_CALL|C_RET,    0, 0,        0,        32'h4,        1, 0, 1));
    tbl.push_back(v(C_BP|C_RET,           0, 0,        0,        32'h704,      1, 0, 0));
    tbl.push_back(v(C_BP|C_CALL,          0, 0,        32'h900,  32'h900,      1, 0, 1));
    tbl.push_back(v(C_JTAG,               0, 0,        0,        32'h0,        0, 0, 0));
    tbl.push_back(v(0,                    0, 0,        0,        32'h0,        1, 0, 0));
    tbl.push_back(v(0,                    0, 0,        0,        32'h4,        1, 0, 0));
    tbl.push_back(v(C_HOLD|C_BP,          0, 0,        32'h800,  32'h4,        1, 0, 0));

    rst = 1'b0;
    drive(0, 0, 0, 0);
    m_pc = 32'h0; m_valid = 1'b0; m_redir = 1'b0; m_ras.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", pc_o, 32'h0);
    chk("reset.valid", {31'b0, pc_valid_o}, 32'h0);
    chk("reset.redirect", {31'b0, redirect_o}, 32'h0);
    chk("reset.ras_count", {29'b0, ras_count_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].ctl, tbl[i].taddr, tbl[i].jaddr, tbl[i].baddr);
      cycle();
      chk($sformatf("vec%0d.pc", i), pc_o, tbl[i].epc);
      chk($sformatf("vec%0d.valid", i), {31'b0, pc_valid_o}, {31'b0, tbl[i].evalid});
      chk($sformatf("vec%0d.redirect", i), {31'b0, redirect_o}, {31'b0, tbl[i].eredir});
      chk($sformatf("vec%0d.ras_count", i), {29'b0, ras_count_o}, 32'(tbl[i].ecnt));
    end

    for (int i = 0; i < 1500; i++) begin
      int ctl;
      logic [31:0] ba;
      ctl = 0;
      if ($urandom_range(0, 63) == 0) ctl |= C_JTAG;
      if ($urandom_range(0, 31) == 0) ctl |= C_TRAP;
      if ($urandom_range(0, 31) == 0) ctl |= C_PE;
      if ($urandom_range(0, 15) == 0) ctl |= C_JMP;
      if ($urandom_range(0, 7) == 0)  ctl |= C_HOLD;
      if ($urandom_range(0, 3) == 0)  ctl |= C_NRDY;
      if ($urandom_range(0, 1) == 0)  ctl |= C_BP;
      if ($urandom_range(0, 2) == 0)  ctl |= C_CALL;
      if ($urandom_range(0, 2) == 0)  ctl |= C_RET;
      ba = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom() & 32'hFFFF_FFFC);
      drive(ctl, $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC, ba);
      if ($urandom_range(0, 1) == 0) bp_taken_i = 1'b0;
      cycle();
      chk_model($sformatf("rnd%0d", i));
    end

    drive(C_JMP, 0, 32'h2000, 0);
    cycle();
    chk_model("pre_rst.jmp");
    drive(C_BP|C_CALL, 0, 0, 32'h3000);
    cycle();
    chk_model("pre_rst.call");
    drive(C_NRDY, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst.pc", pc_o, 32'h0);
    chk("async_rst.valid", {31'b0, pc_valid_o}, 32'h0);
    chk("async_rst.redirect", {31'b0, redirect_o}, 32'h0);
    chk("async_rst.ras_count", {29'b0, ras_count_o}, 32'h0);
    m_pc = 32'h0; m_valid = 1'b0; m_redir = 1'b0; m_ras.delete();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_model($sformatf("post_rst%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
